// File: rtl/tcb_lib_multiplexer_pkg.sv
// Shared types for the TCB multiplexer slice.
//   tcb_arb_t : arbitration mode (round-robin or fixed priority, index 0 highest)
//   tcb_req_t : request payload carried alongside vld
//   tcb_rsp_t : response payload returned TCB_DLY cycles after the handshake
//   TCB_DLY   : response delay of the bus, taken from the interface configuration
package tcb_lib_multiplexer_pkg;

  typedef enum logic {TCB_ARB_RR, TCB_ARB_FIX} tcb_arb_t;

  localparam int unsigned TCB_DLY = 1;

  typedef struct packed {
    logic        lck;  // keep the bus for the next transfer of this manager
    logic        wen;
    logic [3:0]  ben;
    logic [31:0] adr;
    logic [31:0] wdt;
  } tcb_req_t;

  typedef struct packed {
    logic [31:0] rdt;
    logic        err;
  } tcb_rsp_t;

endpackage

// File: rtl/tcb_lib_multiplexer_arbiter.sv
// Combinational grant selection for the TCB multiplexer.
//   i_req      : per-manager vld
//   i_ptr      : round-robin start index (ignored in fixed mode)
//   i_ovr      : force the grant to i_ovr_gnt (bus lock or stalled transfer)
//   i_ovr_gnt  : forced grant index
//   i_last_gnt : grant kept when nobody requests
//   o_gnt      : selected index
module tcb_lib_multiplexer_arbiter
  import tcb_lib_multiplexer_pkg::*;
#(
  parameter int unsigned IFN = 3,
  parameter tcb_arb_t    ARB = TCB_ARB_RR,
  parameter int unsigned IFL = (IFN > 1) ? $clog2(IFN) : 1
)(
  input  logic [IFN-1:0] i_req,
  input  logic [IFL-1:0] i_ptr,
  input  logic           i_ovr,
  input  logic [IFL-1:0] i_ovr_gnt,
  input  logic [IFL-1:0] i_last_gnt,
  output logic [IFL-1:0] o_gnt
);

  logic [IFL-1:0] w_start;

  // Fixed priority is round-robin with the scan always starting at 0.
  assign w_start = (ARB == TCB_ARB_FIX) ? '0 : i_ptr;

  // Rotate-and-find-first: scan IFN slots from w_start with wrap.
  // With IFN=1 this collapses to a constant 0.
  always_comb begin : p_pick
    int   j;
    logic found;
    j     = 0;
    found = 1'b0;
    o_gnt = i_last_gnt;
    if (i_ovr) begin
      o_gnt = i_ovr_gnt;
    end else begin
      for (int k = 0; k < int'(IFN); k++) begin
        j = int'(w_start) + k;
        if (j >= int'(IFN)) j = j - int'(IFN);
        if (!found && i_req[j]) begin
          o_gnt = j[IFL-1:0];
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tcb_lib_multiplexer.sv
// N-to-1 TCB multiplexer: IFN managers share one subordinate.
//   clk, rst   : clock, synchronous active-high reset
//   i_sub_vld/i_sub_req/o_sub_rdy/o_sub_rsp : manager-facing ports, one per manager
//   o_man_vld/o_man_req/i_man_rdy/i_man_rsp : port to the shared subordinate
//   o_gnt      : current grant index (monitor)
// Requests pass through combinationally; responses are steered back to the
// issuer TCB_DLY cycles after its handshake.
module tcb_lib_multiplexer
  import tcb_lib_multiplexer_pkg::*;
#(
  parameter int unsigned IFN = 3,
  parameter tcb_arb_t    ARB = TCB_ARB_RR,
  parameter int unsigned IFL = (IFN > 1) ? $clog2(IFN) : 1
)(
  input  logic                clk,
  input  logic                rst,
  input  logic     [IFN-1:0] i_sub_vld,
  input  tcb_req_t [IFN-1:0] i_sub_req,
  output logic     [IFN-1:0] o_sub_rdy,
  output tcb_rsp_t [IFN-1:0] o_sub_rsp,
  output logic                o_man_vld,
  output tcb_req_t            o_man_req,
  input  logic                i_man_rdy,
  input  tcb_rsp_t            i_man_rsp,
  output logic     [IFL-1:0] o_gnt
);

  localparam int unsigned DLY = TCB_DLY;

  logic [IFL-1:0] r_ptr, r_lck_gnt, r_gnt;
  logic           r_lck_own, r_hold;
  logic [IFL-1:0] w_arb_gnt, w_gnt, w_rsp_sel;
  logic           w_hs, w_rsp_vld;

  // A lock outranks a stalled transfer; both pin the grant.
  tcb_lib_multiplexer_arbiter #(.IFN(IFN), .ARB(ARB), .IFL(IFL)) u_arb (
    .i_req      (i_sub_vld),
    .i_ptr      (r_ptr),
    .i_ovr      (r_lck_own | r_hold),
    .i_ovr_gnt  (r_lck_own ? r_lck_gnt : r_gnt),
    .i_last_gnt (r_gnt),
    .o_gnt      (w_arb_gnt)
  );

  assign w_gnt     = rst ? '0 : w_arb_gnt;
  assign o_gnt     = w_gnt;
  assign o_man_vld = ~rst & i_sub_vld[w_gnt];
  assign o_man_req = i_sub_req[w_gnt];
  assign w_hs      = o_man_vld & i_man_rdy;

  always_comb begin
    o_sub_rdy = '0;
    if (!rst) o_sub_rdy[w_gnt] = i_man_rdy;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_hold    <= 1'b0;
      r_lck_own <= 1'b0;
      r_lck_gnt <= '0;
    end else begin
      r_gnt  <= w_gnt;
      r_hold <= o_man_vld & ~i_man_rdy;
      if (w_hs) begin
        if (o_man_req.lck) begin
          // ptr is left alone so the rotation resumes where it was once unlocked
          r_lck_own <= 1'b1;
          r_lck_gnt <= w_gnt;
        end else begin
          r_lck_own <= 1'b0;
          if (ARB == TCB_ARB_RR)
            r_ptr <= (w_gnt == IFL'(IFN-1)) ? '0 : w_gnt + 1'b1;
        end
      end
    end
  end

  // Response steering: remember who handshook, DLY cycles deep.
  generate
    if (DLY == 0) begin : g_nodly
      assign w_rsp_vld = w_hs;
      assign w_rsp_sel = w_gnt;
    end else begin : g_dly
      logic [DLY-1:0]          r_dly_vld;
      logic [DLY-1:0][IFL-1:0] r_dly_sel;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_dly_vld <= '0;
          r_dly_sel <= '0;
        end else begin
          r_dly_vld[0] <= w_hs;
          r_dly_sel[0] <= w_gnt;
          for (int i = 1; i < int'(DLY); i++) begin
            r_dly_vld[i] <= r_dly_vld[i-1];
            r_dly_sel[i] <= r_dly_sel[i-1];
          end
        end
      end
      assign w_rsp_vld = r_dly_vld[DLY-1];
      assign w_rsp_sel = r_dly_sel[DLY-1];
    end
  endgenerate

  always_comb begin
    o_sub_rsp = '0;
    if (w_rsp_vld && !rst) o_sub_rsp[w_rsp_sel] = i_man_rsp;
  end

endmodule

// File: tb/tb_tcb_lib_multiplexer.sv
// Bench for tcb_lib_multiplexer: a round-robin instance (k=0) and a fixed-priority
// instance (k=1), each checked every cycle against a rule-level model, plus
// directed literal expectations per scenario.
module tb_tcb_lib_multiplexer;
  import tcb_lib_multiplexer_pkg::*;

  localparam int N   = 3;
  localparam int DLY = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic     [N-1:0] s_vld [2];
  tcb_req_t [N-1:0] s_req [2];
  logic             m_rdy [2];
  tcb_rsp_t         m_rsp [2];

  logic     [N-1:0] o0_sub_rdy, o1_sub_rdy;
  tcb_rsp_t [N-1:0] o0_sub_rsp, o1_sub_rsp;
  logic             o0_man_vld, o1_man_vld;
  tcb_req_t         o0_man_req, o1_man_req;
  logic     [1:0]   o0_gnt, o1_gnt;

  tcb_lib_multiplexer #(.IFN(N), .ARB(TCB_ARB_RR)) u_rr (
    .clk(clk), .rst(rst),
    .i_sub_vld(s_vld[0]), .i_sub_req(s_req[0]), .o_sub_rdy(o0_sub_rdy), .o_sub_rsp(o0_sub_rsp),
    .o_man_vld(o0_man_vld), .o_man_req(o0_man_req), .i_man_rdy(m_rdy[0]), .i_man_rsp(m_rsp[0]),
    .o_gnt(o0_gnt)
  );

  tcb_lib_multiplexer #(.IFN(N), .ARB(TCB_ARB_FIX)) u_fix (
    .clk(clk), .rst(rst),
    .i_sub_vld(s_vld[1]), .i_sub_req(s_req[1]), .o_sub_rdy(o1_sub_rdy), .o_sub_rsp(o1_sub_rsp),
    .o_man_vld(o1_man_vld), .o_man_req(o1_man_req), .i_man_rdy(m_rdy[1]), .i_man_rsp(m_rsp[1]),
    .o_gnt(o1_gnt)
  );

  // Shared subordinate: small memory answering one cycle after each handshake.
  // Idle cycles return a recognisable non-zero value so stray routing shows up.
  logic [31:0] mem0 [16];
  logic [31:0] mem1 [16];
  always @(posedge clk) begin
    if (o0_man_vld && m_rdy[0]) begin
      if (o0_man_req.wen) begin
        mem0[o0_man_req.adr[5:2]] <= o0_man_req.wdt;
        m_rsp[0] <= '{rdt: 32'hA500_0000 | o0_man_req.adr, err: 1'b0};
      end else m_rsp[0] <= '{rdt: mem0[o0_man_req.adr[5:2]], err: 1'b0};
    end else m_rsp[0] <= '{rdt: 32'hDEAD_BEEF, err: 1'b1};
  end
  always @(posedge clk) begin
    if (o1_man_vld && m_rdy[1]) begin
      if (o1_man_req.wen) begin
        mem1[o1_man_req.adr[5:2]] <= o1_man_req.wdt;
        m_rsp[1] <= '{rdt: 32'hA500_0000 | o1_man_req.adr, err: 1'b0};
      end else m_rsp[1] <= '{rdt: mem1[o1_man_req.adr[5:2]], err: 1'b0};
    end else m_rsp[1] <= '{rdt: 32'hDEAD_BEEF, err: 1'b1};
  end

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic chk(input int k, input string nm, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s dut=%0d cyc=%0d got=%h exp=%h", nm, k, cyc, got, exp);
    end
  endtask

  // Model state per instance. rsp_to[k][c] = issuer+1 whose response is due in cycle c (0 = none).
  int m_lck_own [2];
  int m_lck_gnt [2];
  int m_hold    [2];
  int m_last    [2];
  int m_ptr     [2];
  int rsp_to    [2][1024];

  task automatic model_step(input int k);
    logic     [N-1:0] vld, a_rdy, e_rdy;
    tcb_req_t [N-1:0] rq;
    tcb_rsp_t [N-1:0] a_rsp;
    tcb_rsp_t         mr, e;
    tcb_req_t         a_mreq;
    logic             rdy_in, a_mvld, e_mvld;
    logic     [1:0]   a_gnt;
    int               g;
    bit               found;
    vld = s_vld[k]; rq = s_req[k]; rdy_in = m_rdy[k]; mr = m_rsp[k];
    if (k == 0) begin
      a_gnt = o0_gnt; a_mvld = o0_man_vld; a_mreq = o0_man_req; a_rdy = o0_sub_rdy; a_rsp = o0_sub_rsp;
    end else begin
      a_gnt = o1_gnt; a_mvld = o1_man_vld; a_mreq = o1_man_req; a_rdy = o1_sub_rdy; a_rsp = o1_sub_rsp;
    end
    g = 0; e_mvld = 1'b0; e_rdy = '0;
    if (!rst) begin
      if (m_lck_own[k] != 0)  g = m_lck_gnt[k];
      else if (m_hold[k] != 0) g = m_last[k];
      else begin
        g = m_last[k]; found = 0;
        for (int n = 0; n < N; n++) begin
          int i;
          i = (k == 1) ? n : (m_ptr[k] + n) % N;
          if (!found && vld[i]) begin g = i; found = 1; end
        end
      end
      e_mvld = vld[g];
      e_rdy  = rdy_in ? (3'b001 << g) : 3'b000;
    end
    chk(k, "gnt", a_gnt, g);
    chk(k, "man_vld", a_mvld, e_mvld);
    chk(k, "sub_rdy", a_rdy, e_rdy);
    if (e_mvld) chk(k, "man_req", a_mreq, rq[g]);
    for (int i = 0; i < N; i++) begin
      e = (!rst && rsp_to[k][cyc] == i + 1) ? mr : '0;
      chk(k, "sub_rsp", a_rsp[i], e);
    end
    if (rst) begin
      m_lck_own[k] = 0; m_lck_gnt[k] = 0; m_hold[k] = 0; m_last[k] = 0; m_ptr[k] = 0;
      for (int d = 1; d <= DLY; d++) rsp_to[k][cyc + d] = 0;
    end else begin
      if (e_mvld && rdy_in) begin
        rsp_to[k][cyc + DLY] = g + 1;
        if (rq[g].lck) begin m_lck_own[k] = 1; m_lck_gnt[k] = g; end
        else begin
          m_lck_own[k] = 0;
          if (k == 0) m_ptr[k] = (g + 1) % N;
        end
      end
      m_hold[k] = (e_mvld && !rdy_in) ? 1 : 0;
      m_last[k] = g;
    end
  endtask

  always @(negedge clk) begin
    model_step(0);
    model_step(1);
    cyc++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic setr(input int k, input int i, input bit v, input bit wen, input bit lck,
                      input logic [31:0] adr, input logic [31:0] wdt);
    s_vld[k][i] = v;
    s_req[k][i] = '{lck: lck, wen: wen, ben: 4'hF, adr: adr, wdt: wdt};
  endtask

  initial begin
    s_vld[0] = '0; s_vld[1] = '0; s_req[0] = '0; s_req[1] = '0;
    m_rdy[0] = 1'b1; m_rdy[1] = 1'b1;
    rst = 1'b1;
    // Reset with every manager requesting: nothing may leak out.
    s_vld[0] = 3'b111;
    repeat (3) tick();
    @(negedge clk);
    chk(0, "rst_gnt", o0_gnt, 0);
    chk(0, "rst_mvld", o0_man_vld, 0);
    chk(0, "rst_rdy", o0_sub_rdy, 0);
    tick(); rst = 1'b0; s_vld[0] = '0;

    // 1: single manager write then read back
    tick(); setr(0, 1, 1, 1, 0, 32'h10, 32'h7654_3210);
    @(negedge clk); chk(0, "t1_gnt", o0_gnt, 1); chk(0, "t1_wadr", o0_man_req.adr, 32'h10);
    tick(); setr(0, 1, 1, 0, 0, 32'h10, 32'h0);
    @(negedge clk); chk(0, "t1_rvld", o0_man_vld, 1); chk(0, "t1_rwen", o0_man_req.wen, 0);
    tick(); s_vld[0] = '0;
    @(negedge clk);
    chk(0, "t1_rdt", o0_sub_rsp[1].rdt, 32'h7654_3210);
    chk(0, "t1_rsp0", o0_sub_rsp[0], 0);
    chk(0, "t1_rsp2", o0_sub_rsp[2], 0);

    // restart from ptr=0 for the ordering test
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    for (int i = 0; i < N; i++) setr(0, i, 1, 0, 0, 32'h20 + 4 * i, 32'h0);

    // 2: all three requesting every cycle
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); chk(0, "t2_ord", o0_gnt, c % 3); chk(0, "t2_vld", o0_man_vld, 1);
      tick();
    end

    // 3: backpressure while sub[2] owns the bus
    s_vld[0] = '0; setr(0, 2, 1, 0, 0, 32'h44, 32'h0); m_rdy[0] = 1'b0;
    @(negedge clk); chk(0, "t3_gnt_a", o0_gnt, 2);
    tick(); setr(0, 0, 1, 0, 0, 32'h40, 32'h0);
    @(negedge clk); chk(0, "t3_gnt_b", o0_gnt, 2); chk(0, "t3_adr_b", o0_man_req.adr, 32'h44);
    tick();
    @(negedge clk); chk(0, "t3_gnt_c", o0_gnt, 2); chk(0, "t3_rdy0", o0_sub_rdy, 0);
    tick(); m_rdy[0] = 1'b1;
    @(negedge clk); chk(0, "t3_gnt_d", o0_gnt, 2); chk(0, "t3_adr_d", o0_man_req.adr, 32'h44);
    tick();
    @(negedge clk); chk(0, "t3_next", o0_gnt, 0);
    tick(); s_vld[0] = '0;

    // 4: lock by sub[0] with sub[1] waiting, including an idle locked cycle
    setr(0, 0, 1, 0, 1, 32'h30, 32'h0);
    @(negedge clk); chk(0, "t4_gnt0", o0_gnt, 0);
    tick(); setr(0, 1, 1, 0, 0, 32'h50, 32'h0);
    @(negedge clk); chk(0, "t4_gnt1", o0_gnt, 0); chk(0, "t4_rdy1", o0_sub_rdy[1], 0);
    tick(); s_vld[0][0] = 1'b0;
    @(negedge clk); chk(0, "t4_idle_gnt", o0_gnt, 0); chk(0, "t4_idle_vld", o0_man_vld, 0);
    tick(); setr(0, 0, 1, 0, 0, 32'h34, 32'h0);
    @(negedge clk); chk(0, "t4_unlk", o0_gnt, 0);
    tick(); s_vld[0][0] = 1'b0;
    @(negedge clk); chk(0, "t4_after", o0_gnt, 1);

    // 6: reset right after a read handshake drops its response
    tick(); setr(0, 1, 1, 0, 0, 32'h10, 32'h0);
    @(negedge clk); chk(0, "t6_gnt", o0_gnt, 1);
    tick(); rst = 1'b1; s_vld[0] = 3'b111;
    @(negedge clk);
    for (int i = 0; i < N; i++) chk(0, "t6_rsp_rst", o0_sub_rsp[i], 0);
    tick(); rst = 1'b0;
    @(negedge clk);
    chk(0, "t6_ptr0", o0_gnt, 0);
    for (int i = 0; i < N; i++) chk(0, "t6_rsp_rel", o0_sub_rsp[i], 0);
    tick(); s_vld[0] = '0;

    // 5: fixed priority, sub[0] and sub[2] always requesting
    setr(1, 0, 1, 0, 0, 32'h60, 32'h0);
    setr(1, 2, 1, 0, 0, 32'h68, 32'h0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); chk(1, "t5_gnt", o1_gnt, 0);
      tick();
    end
    s_vld[1][0] = 1'b0;
    @(negedge clk); chk(1, "t5_alone", o1_gnt, 2);
    tick(); s_vld[1] = '0;

    repeat (3) tick();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
